// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss-handling controller that refills one cache block from a pipelined,
// multi-cycle main memory. On an accepted miss it issues one word request per
// cycle until the whole block has been requested. It writes every in-order
// response into the data array. The response that completes the block also
// writes the tag array, and the controller then drops the pipeline stall.
//
// Optional feature macro: CRITICAL_WORD_FIRST_EN
//   When defined, the fill starts at the word that missed and wraps around the
//   block end. When undefined, every fill runs from word 0 upwards.
//
// Parameters
//   DATA_W          memory word width in bits (multiple of 8)
//   ADDR_W          byte-address width
//   WORDS_PER_BLOCK words per cache block (power of two, >= 2)
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   miss_valid       miss request, sampled only while idle
//   miss_addr        byte address of the missing access
//   fsm_busy         fill in progress (pipeline stall), registered
//   mem_en           memory request strobe, registered
//   mem_addr         byte address of the current request, registered
//   mem_data_valid   memory returns one in-order word this cycle
//   mem_data         returned word
//   write_data_array write fill_data at fill_word_idx (combinational)
//   fill_word_idx    word offset within the block (combinational)
//   fill_data        pass-through of mem_data
//   write_tag_array  one-cycle pulse on the block-completing response
//   fill_addr        latched block base address, registered
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_valid,
  input  logic [ADDR_W-1:0]                  miss_addr,
  output logic                               fsm_busy,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic                               mem_data_valid,
  input  logic [DATA_W-1:0]                  mem_data,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               write_tag_array,
  output logic [ADDR_W-1:0]                  fill_addr
);

  localparam int BOFF  = $clog2(DATA_W / 8);
  localparam int IDXW  = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDXW + 1;

  // Byte-within-word plus word-within-block bits, cleared to form the base.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << (BOFF + IDXW)) - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic              acceptMiss;
  logic              wrData;
  logic              tagWrite;
  logic [IDXW-1:0]   wordIdx;

  logic [CNT_W-1:0]  reqCnt;
  logic [CNT_W-1:0]  rspCnt;
  logic [IDXW-1:0]   reqIdx;
  logic [IDXW-1:0]   reqIdxNext;
  logic [IDXW-1:0]   rspIdx;
  logic [IDXW-1:0]   firstIdx;
  logic [ADDR_W-1:0] fillAddrQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic              memEnQ;

  function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] addr);
    return addr & ~OFF_MASK;
  endfunction

  function automatic logic [ADDR_W-1:0] wordAddr(input logic [ADDR_W-1:0] base,
                                                 input logic [IDXW-1:0]   idx);
    return base | (ADDR_W'(idx) << BOFF);
  endfunction

`ifdef CRITICAL_WORD_FIRST_EN
  // Word that missed; the fill starts here and wraps modulo the block size.
  logic [IDXW-1:0] startIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startIdx <= '0;
    end else if (acceptMiss) begin
      startIdx <= firstIdx;
    end
  end

  assign firstIdx = miss_addr[BOFF+IDXW-1:BOFF];
  assign reqIdx   = startIdx + reqCnt[IDXW-1:0];
  assign rspIdx   = startIdx + rspCnt[IDXW-1:0];
`else
  assign firstIdx = '0;
  assign reqIdx   = reqCnt[IDXW-1:0];
  assign rspIdx   = rspCnt[IDXW-1:0];
`endif

  // Natural IDXW-bit overflow gives the wrap around the block end.
  assign reqIdxNext = reqIdx + IDXW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Write strobes are decoded from state so that stray responses while idle,
  // or during reset, never reach the arrays.
  always_comb begin
    stateNext  = state;
    acceptMiss = 1'b0;
    wrData     = 1'b0;
    tagWrite   = 1'b0;
    wordIdx    = '0;
    case (state)
      IDLE: begin
        if (miss_valid) begin
          acceptMiss = 1'b1;
          stateNext  = FILL;
        end
      end
      FILL: begin
        if (mem_data_valid) begin
          wrData  = 1'b1;
          wordIdx = rspIdx;
          if (rspCnt == LAST_CNT) begin
            tagWrite  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request and response sides advance independently; a request and a
  // response may land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqCnt    <= '0;
      rspCnt    <= '0;
      fillAddrQ <= '0;
      memAddrQ  <= '0;
      memEnQ    <= 1'b0;
    end else if (acceptMiss) begin
      reqCnt    <= '0;
      rspCnt    <= '0;
      fillAddrQ <= blockBase(miss_addr);
      memAddrQ  <= wordAddr(blockBase(miss_addr), firstIdx);
      memEnQ    <= 1'b1;
    end else if (state == FILL) begin
      if (memEnQ) begin
        reqCnt <= reqCnt + CNT_W'(1);
        if (reqCnt == LAST_CNT) begin
          memEnQ   <= 1'b0;
          memAddrQ <= '0;
        end else begin
          memAddrQ <= wordAddr(fillAddrQ, reqIdxNext);
        end
      end
      if (wrData) begin
        rspCnt <= rspCnt + CNT_W'(1);
      end
      if (tagWrite) begin
        memEnQ   <= 1'b0;
        memAddrQ <= '0;
      end
    end
  end

  assign fsm_busy         = (state == FILL);
  assign mem_en           = memEnQ;
  assign mem_addr         = memAddrQ;
  assign fill_addr        = fillAddrQ;
  assign write_data_array = wrData;
  assign fill_word_idx    = wordIdx;
  assign fill_data        = mem_data;
  assign write_tag_array  = tagWrite;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
//
// Directed and randomized block fills against cache_fill_fsm. Each fill is
// described by its miss address, memory latency and a response gap pattern;
// the expected request addresses, write indices, data and tag pulse timing
// are derived from those with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int WPB    = 8;
  localparam int IDXW   = $clog2(WPB);
  localparam int BYTES  = DATA_W / 8;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              miss_valid = 1'b0;
  logic [ADDR_W-1:0] miss_addr = '0;
  logic              fsm_busy;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              write_data_array;
  logic [IDXW-1:0]   fill_word_idx;
  logic [DATA_W-1:0] fill_data;
  logic              write_tag_array;
  logic [ADDR_W-1:0] fill_addr;

  int nCompared = 0;
  int nMismatch = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .WORDS_PER_BLOCK(WPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .miss_valid(miss_valid),
    .miss_addr(miss_addr),
    .fsm_busy(fsm_busy),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid),
    .mem_data(mem_data),
    .write_data_array(write_data_array),
    .fill_word_idx(fill_word_idx),
    .fill_data(fill_data),
    .write_tag_array(write_tag_array),
    .fill_addr(fill_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    assert (got === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string where);
    check({where, " fsm_busy"}, 32'(fsm_busy), 32'd0);
    check({where, " mem_en"}, 32'(mem_en), 32'd0);
    check({where, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({where, " write_data_array"}, 32'(write_data_array), 32'd0);
    check({where, " write_tag_array"}, 32'(write_tag_array), 32'd0);
    check({where, " fill_word_idx"}, 32'(fill_word_idx), 32'd0);
    check({where, " fill_addr"}, 32'(fill_addr), 32'd0);
  endtask

  // One complete fill. Must be entered at a falling edge; that cycle is the
  // miss cycle (cycle 0). Requests are expected in cycles 1..WPB, response j
  // is driven in rspCyc[j], the tag pulse rides on the last response and the
  // controller must be idle in the cycle after it. With holdMiss the miss
  // stays asserted throughout and on return, so the caller's next fill is
  // accepted in that first idle cycle. abortAfter>0 pulses reset right after
  // that many responses have been written.
  task automatic runFill(input logic [ADDR_W-1:0] addr, input int lat, input int gapMode,
                         input bit holdMiss, input int abortAfter, input bit idlePulse);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] expAddr;
    int                start;
    int                rspCyc[WPB];
    logic [DATA_W-1:0] data[WPB];
    int                last;
    int                j;
    int                gap;

    base  = addr & ~ADDR_W'(WPB * BYTES - 1);
    start = CWF ? (int'(addr) / BYTES) % WPB : 0;
    for (int k = 0; k < WPB; k++) begin
      gap = 0;
      if (k > 0 && gapMode == 1) gap = 1;
      if (k > 0 && gapMode == 2) gap = int'($urandom_range(0, 2));
      if (k == 0) rspCyc[k] = 1 + lat;
      else        rspCyc[k] = (rspCyc[k-1] + 1 + gap > 1 + k + lat) ?
                              rspCyc[k-1] + 1 + gap : 1 + k + lat;
      data[k] = DATA_W'($urandom);
    end
    last = rspCyc[WPB-1];

    miss_valid     = 1'b1;
    miss_addr      = addr;
    mem_data_valid = 1'b0;
    #1;
    check("idle fsm_busy", 32'(fsm_busy), 32'd0);
    check("idle mem_en", 32'(mem_en), 32'd0);

    j = 0;
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      miss_valid = holdMiss;
      miss_addr  = ADDR_W'($urandom);
      if (c <= last) begin
        mem_data_valid = (j < WPB) && (rspCyc[j] == c);
        mem_data       = mem_data_valid ? data[j] : DATA_W'($urandom);
      end else begin
        mem_data_valid = idlePulse;
        mem_data       = DATA_W'($urandom);
      end
      #1;
      if (c <= last) begin
        check("fsm_busy", 32'(fsm_busy), 32'd1);
        check("fill_addr", 32'(fill_addr), 32'(base));
        check("mem_en", 32'(mem_en), 32'(c <= WPB));
        if (c <= WPB) begin
          expAddr = base + ADDR_W'(((start + c - 1) % WPB) * BYTES);
          check("mem_addr", 32'(mem_addr), 32'(expAddr));
        end
        check("write_data_array", 32'(write_data_array), 32'(mem_data_valid));
        if (mem_data_valid) begin
          check("fill_word_idx", 32'(fill_word_idx), 32'((start + j) % WPB));
          check("fill_data", 32'(fill_data), 32'(data[j]));
          check("write_tag_array", 32'(write_tag_array), 32'(j == WPB - 1));
          j++;
          if (j == abortAfter) begin
            #1;
            rst_n = 1'b0;
            #1;
            checkAllZero("abort");
            miss_valid     = 1'b0;
            mem_data_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            #1;
            check("post-abort fsm_busy", 32'(fsm_busy), 32'd0);
            check("post-abort write_tag_array", 32'(write_tag_array), 32'd0);
            return;
          end
        end else begin
          check("write_tag_array idle", 32'(write_tag_array), 32'd0);
        end
      end else begin
        check("end fsm_busy", 32'(fsm_busy), 32'd0);
        check("end mem_en", 32'(mem_en), 32'd0);
        check("end write_data_array", 32'(write_data_array), 32'd0);
        check("end write_tag_array", 32'(write_tag_array), 32'd0);
      end
    end
    mem_data_valid = 1'b0;
  endtask

  initial begin
    bit hold;

    // Reset state, including a stray response while in reset.
    mem_data_valid = 1'b1;
    miss_valid     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");
    mem_data_valid = 1'b0;
    miss_valid     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal fill: latency 4, miss in the middle of the block.
    runFill(16'h1234, 4, 0, 1'b0, -1, 1'b0);
    // Latency 1: request and response overlap every cycle.
    runFill(16'hBEEE, 1, 0, 1'b0, -1, 1'b0);
    // Gapped responses, one idle cycle between each.
    runFill(16'h0F02, 2, 1, 1'b0, -1, 1'b0);
    // Miss held through the fill, response pulsed while idle, and the
    // follow-on miss accepted in the first idle cycle.
    runFill(16'h0ABC, 3, 0, 1'b1, -1, 1'b1);
    runFill(16'h4442, 2, 0, 1'b0, -1, 1'b1);
    // Reset after three responses, then a clean refill of the same block.
    runFill(16'h2226, 2, 0, 1'b0, 3, 1'b0);
    runFill(16'h2226, 2, 0, 1'b0, -1, 1'b0);
    // Miss on word 3 (wraps when critical-word-first is built in).
    runFill(16'h1236, 4, 0, 1'b0, -1, 1'b0);
    // Miss on the last word of a block at the top of the address space.
    runFill(16'hFFFF, 1, 2, 1'b0, -1, 1'b0);

    // Randomized fills; the last one always releases the miss.
    for (int n = 0; n < 24; n++) begin
      hold = (n < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      runFill(ADDR_W'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 2)),
              hold, -1, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    check("final fsm_busy", 32'(fsm_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Parametrised miss-handling controller that refills one cache block from a pipelined, multi-cycle main memory. It sits between the processor's instruction/data cache arrays and the shared memory port, used by the pipelined successor of the single-cycle core. It issues one word request per cycle, counts in-order responses and writes each returned word into the data array. It writes the tag array on the final word and then releases the pipeline stall.

## Interface
Parameters:
- DATA_W, 16, memory word width in bits; multiple of 8
- ADDR_W, 16, byte-address width
- WORDS_PER_BLOCK, 8, words per cache block; power of two, ≥2

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss_valid  in  1  cache miss detected; sampled only in IDLE
- miss_addr  in  ADDR_W  byte address of the missing access
- fsm_busy  out  1  high while a fill is in progress (pipeline stall)
- mem_en  out  1  memory request strobe, one word per cycle
- mem_addr  out  ADDR_W  byte address of the current request
- mem_data_valid  in  1  memory returns one word this cycle, in request order
- mem_data  in  DATA_W  returned word
- write_data_array  out  1  write fill_data at fill_word_idx this cycle
- fill_word_idx  out  log2(WORDS_PER_BLOCK)  word offset within block
- fill_data  out  DATA_W  equals mem_data (combinational pass-through)
- write_tag_array  out  1  single-cycle pulse: block complete, write tag/valid
- fill_addr  out  ADDR_W  latched block base address for the tag write

## Operation
- Word offset bits: BOFF = log2(DATA_W/8); block offset spans bits [BOFF+log2(WORDS_PER_BLOCK)-1 : BOFF].
- IDLE: fsm_busy=0. When miss_valid=1, do the following on the next edge: latch fill_addr = miss_addr with block-offset and byte bits cleared; clear req_cnt and rsp_cnt; go to FILL.
- FILL: fsm_busy=1.
  - mem_en=1 while req_cnt < WORDS_PER_BLOCK.
  - mem_addr = fill_addr + (req_idx << BOFF).
  - req_cnt increments each cycle that mem_en=1.
- Responses in FILL: on each cycle with mem_data_valid=1:
  - write_data_array=1, fill_word_idx = rsp_idx, fill_data = mem_data.
  - rsp_cnt increments.
- Request and response counting are independent. A response can arrive in the same cycle as a request, including at latency 1.
- The response that makes rsp_cnt reach WORDS_PER_BLOCK also asserts write_tag_array that cycle. The FSM returns to IDLE on the next edge, so fsm_busy falls one cycle after the last response.
- Without the macro in Configuration: req_idx = req_cnt and rsp_idx = rsp_cnt, both modulo WORDS_PER_BLOCK.
- Ignored inputs:
  - miss_valid while busy.
  - mem_data_valid in IDLE, which produces no writes.
  - Responses beyond WORDS_PER_BLOCK are unreachable, because the state leaves FILL first.
- The FSM never issues more than WORDS_PER_BLOCK requests per fill.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, counters 0, fill_addr 0. Held at 0: fsm_busy, mem_en, mem_addr, write_data_array, write_tag_array, fill_word_idx. Reset mid-fill aborts immediately with no tag write.
- Cycle 0: miss_valid sampled in IDLE. Cycles 1..WORDS_PER_BLOCK: requests issued back to back.
- With memory latency L (first response L cycles after first request), the last response is at cycle WORDS_PER_BLOCK+L. write_tag_array is in that same cycle and fsm_busy is low from cycle WORDS_PER_BLOCK+L+1.
- A new miss_valid in the first IDLE cycle after a fill is accepted (no dead cycle beyond the fall of fsm_busy).
- All outputs are registered except fill_data, write_data_array, fill_word_idx and write_tag_array. Those four are decoded from state plus mem_data_valid.

## Configuration
- CRITICAL_WORD_FIRST_EN defined:
  - Latch start_idx = miss_addr block-offset field.
  - req_idx = (start_idx + req_cnt) mod WORDS_PER_BLOCK and rsp_idx = (start_idx + rsp_cnt) mod WORDS_PER_BLOCK, so the fill wraps around the block end.
  - fill_addr is still the block base.
- Not defined: every fill starts at word 0 in ascending order; start_idx logic is absent.

## Test plan
- Defaults, L=4, miss_addr=0x1234 -> fill_addr=0x1230; mem_addr 0x1230,0x1232,…,0x123E in cycles 1–8; writes idx 0–7 in cycles 5–12; write_tag_array in cycle 12; fsm_busy low in cycle 13.
- L=1 back-to-back: request and response overlap every cycle; exactly 8 writes, one tag pulse, no 9th mem_en.
- Gapped responses (mem_data_valid toggling 1,0,1,…): rsp_cnt advances only on valid; the tag write coincides with the 8th valid; fsm_busy stays high throughout.
- miss_valid held high through the fill and mem_data_valid pulsed in IDLE -> no second fill starts until IDLE; no writes in IDLE; a new fill starts the cycle after fsm_busy falls.
- rst_n pulsed low after 3 responses -> all outputs 0 immediately, no write_tag_array; the next miss restarts at word 0.
- With CRITICAL_WORD_FIRST_EN, miss_addr=0x1236: request order 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234; fill_word_idx 3,4,5,6,7,0,1,2.
